// File: rtl/multicycle_alu_if.sv
// Request/response bundle between the execute-stage control FSM (master)
// and the multicycle ALU (slave).
interface multicycle_alu_if #(
  parameter int WIDTH       = 32,
  parameter int SHAMT_WIDTH = 5
);
  logic                   start;
  logic [3:0]             ALUOperation;
  logic [WIDTH-1:0]       A;
  logic [WIDTH-1:0]       B;
  logic [SHAMT_WIDTH-1:0] Shamt;
  logic                   busy;
  logic                   done;
  logic                   Zero;
  logic [WIDTH-1:0]       ALUResult;
  logic [WIDTH-1:0]       HI;
  logic [WIDTH-1:0]       LO;

  modport master (
    output start, ALUOperation, A, B, Shamt,
    input  busy, done, Zero, ALUResult, HI, LO
  );

  modport slave (
    input  start, ALUOperation, A, B, Shamt,
    output busy, done, Zero, ALUResult, HI, LO
  );
endinterface

// File: rtl/multicycle_alu.sv
// Registered execute-stage ALU: single-cycle MIPS operations plus iterative
// unsigned shift-add multiply and restoring divide into HI/LO.
module multicycle_alu #(
  parameter int               WIDTH       = 32,
  parameter int               SHAMT_WIDTH = 5,
  parameter logic [WIDTH-1:0] MEM_BASE    = 32'h0040_0000
) (
  input logic             clk,
  input logic             reset,
  multicycle_alu_if.slave bus
);
  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_NOR   = 4'b0010;
  localparam logic [3:0] OP_ADD   = 4'b0011;
  localparam logic [3:0] OP_SUB   = 4'b0100;
  localparam logic [3:0] OP_MULTU = 4'b0101;
  localparam logic [3:0] OP_DIVU  = 4'b0110;
  localparam logic [3:0] OP_SRA   = 4'b0111;
  localparam logic [3:0] OP_SLL   = 4'b1000;
  localparam logic [3:0] OP_SRL   = 4'b1001;
  localparam logic [3:0] OP_MEM   = 4'b1010;
  localparam logic [3:0] OP_JR    = 4'b1011;
  localparam logic [3:0] OP_BEQ   = 4'b1100;
  localparam logic [3:0] OP_LUI   = 4'b1110;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;

  localparam logic [SHAMT_WIDTH-1:0] CNT_LAST = SHAMT_WIDTH'(WIDTH - 1);

  logic [1:0]             state_r;
  logic [SHAMT_WIDTH-1:0] cnt_r;
  logic                   busy_r;
  logic                   done_r;
  logic                   zero_r;
  logic [WIDTH-1:0]       result_r;
  logic [WIDTH-1:0]       hi_r;
  logic [WIDTH-1:0]       lo_r;
  logic [2*WIDTH-1:0]     prod_r;
  logic [WIDTH-1:0]       mcand_r;
  logic [WIDTH-1:0]       rem_r;
  logic [WIDTH-1:0]       quo_r;
  logic [WIDTH-1:0]       dvsr_r;

  logic [WIDTH-1:0]       alu_s;
  logic [WIDTH-1:0]       mem_s;
  logic [WIDTH:0]         mul_sum_s;
  logic [2*WIDTH-1:0]     mul_next_s;
  logic [WIDTH:0]         div_shift_s;
  logic [WIDTH-1:0]       rem_next_s;
  logic [WIDTH-1:0]       quo_next_s;

  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.Zero      = zero_r;
  assign bus.ALUResult = result_r;
  assign bus.HI        = hi_r;
  assign bus.LO        = lo_r;

  assign mem_s = bus.A + bus.B - MEM_BASE;

  // Single-cycle result computed straight from the request inputs.
  always_comb begin
    alu_s = {WIDTH{1'b0}};
    case (bus.ALUOperation)
      OP_AND:  alu_s = bus.A & bus.B;
      OP_OR:   alu_s = bus.A | bus.B;
      OP_NOR:  alu_s = ~(bus.A | bus.B);
      OP_ADD:  alu_s = bus.A + bus.B;
      OP_SUB:  alu_s = bus.A - bus.B;
      OP_BEQ:  alu_s = bus.A - bus.B;
      OP_SLL:  alu_s = bus.B << bus.Shamt;
      OP_SRL:  alu_s = bus.B >> bus.Shamt;
      OP_SRA:  alu_s = $unsigned($signed(bus.B) >>> bus.Shamt);
      OP_LUI:  alu_s = {bus.B[15:0], {(WIDTH-16){1'b0}}};
      OP_MEM:  alu_s = mem_s >> 2'd2;
      OP_JR:   alu_s = bus.A;
      default: alu_s = {WIDTH{1'b0}};
    endcase
  end

  // One shift-add multiply step: add multiplicand on LSB, shift product right.
  always_comb begin
    mul_sum_s  = {1'b0, prod_r[2*WIDTH-1:WIDTH]}
               + (prod_r[0] ? {1'b0, mcand_r} : {(WIDTH+1){1'b0}});
    mul_next_s = {mul_sum_s, prod_r[WIDTH-1:1]};
  end

  // One restoring-divide step; a zero divisor always "fits", giving all-ones/A.
  always_comb begin
    div_shift_s = {rem_r, quo_r[WIDTH-1]};
    if (div_shift_s >= {1'b0, dvsr_r}) begin
      rem_next_s = div_shift_s[WIDTH-1:0] - dvsr_r;
      quo_next_s = {quo_r[WIDTH-2:0], 1'b1};
    end else begin
      rem_next_s = div_shift_s[WIDTH-1:0];
      quo_next_s = {quo_r[WIDTH-2:0], 1'b0};
    end
  end

  // Control FSM and all architectural registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= S_IDLE;
      cnt_r    <= {SHAMT_WIDTH{1'b0}};
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      zero_r   <= 1'b0;
      result_r <= {WIDTH{1'b0}};
      hi_r     <= {WIDTH{1'b0}};
      lo_r     <= {WIDTH{1'b0}};
      prod_r   <= {(2*WIDTH){1'b0}};
      mcand_r  <= {WIDTH{1'b0}};
      rem_r    <= {WIDTH{1'b0}};
      quo_r    <= {WIDTH{1'b0}};
      dvsr_r   <= {WIDTH{1'b0}};
    end else begin
      done_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (!bus.start) begin
            state_r <= S_IDLE;
          end else if (bus.ALUOperation == OP_MULTU) begin
            state_r <= S_MUL;
            busy_r  <= 1'b1;
            cnt_r   <= {SHAMT_WIDTH{1'b0}};
            prod_r  <= {{WIDTH{1'b0}}, bus.B};
            mcand_r <= bus.A;
          end else if (bus.ALUOperation == OP_DIVU) begin
            state_r <= S_DIV;
            busy_r  <= 1'b1;
            cnt_r   <= {SHAMT_WIDTH{1'b0}};
            rem_r   <= {WIDTH{1'b0}};
            quo_r   <= bus.A;
            dvsr_r  <= bus.B;
          end else begin
            result_r <= alu_s;
            zero_r   <= (alu_s == {WIDTH{1'b0}});
            done_r   <= 1'b1;
          end
        end
        S_MUL: begin
          prod_r <= mul_next_s;
          if (cnt_r == CNT_LAST) begin
            state_r  <= S_IDLE;
            busy_r   <= 1'b0;
            done_r   <= 1'b1;
            cnt_r    <= {SHAMT_WIDTH{1'b0}};
            hi_r     <= mul_next_s[2*WIDTH-1:WIDTH];
            lo_r     <= mul_next_s[WIDTH-1:0];
            result_r <= mul_next_s[WIDTH-1:0];
            zero_r   <= (mul_next_s[WIDTH-1:0] == {WIDTH{1'b0}});
          end else begin
            cnt_r <= cnt_r + 1'b1;
          end
        end
        S_DIV: begin
          rem_r <= rem_next_s;
          quo_r <= quo_next_s;
          if (cnt_r == CNT_LAST) begin
            state_r  <= S_IDLE;
            busy_r   <= 1'b0;
            done_r   <= 1'b1;
            cnt_r    <= {SHAMT_WIDTH{1'b0}};
            hi_r     <= rem_next_s;
            lo_r     <= quo_next_s;
            result_r <= quo_next_s;
            zero_r   <= (quo_next_s == {WIDTH{1'b0}});
          end else begin
            cnt_r <= cnt_r + 1'b1;
          end
        end
        default: begin
          state_r <= S_IDLE;
          busy_r  <= 1'b0;
          cnt_r   <= {SHAMT_WIDTH{1'b0}};
        end
      endcase
    end
  end
endmodule

// File: tb/tb_multicycle_alu.sv
// Scoreboard-driven bench for multicycle_alu: expectations are pushed at issue
// time from a behavioural model and popped when done pulses.
module tb_multicycle_alu;
  localparam int WIDTH       = 32;
  localparam int SHAMT_WIDTH = 5;
  localparam int VW          = 3*WIDTH + 1;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_NOR   = 4'b0010;
  localparam logic [3:0] OP_ADD   = 4'b0011;
  localparam logic [3:0] OP_SUB   = 4'b0100;
  localparam logic [3:0] OP_MULTU = 4'b0101;
  localparam logic [3:0] OP_DIVU  = 4'b0110;
  localparam logic [3:0] OP_SRA   = 4'b0111;
  localparam logic [3:0] OP_SLL   = 4'b1000;
  localparam logic [3:0] OP_SRL   = 4'b1001;
  localparam logic [3:0] OP_MEM   = 4'b1010;
  localparam logic [3:0] OP_JR    = 4'b1011;
  localparam logic [3:0] OP_BEQ   = 4'b1100;
  localparam logic [3:0] OP_LUI   = 4'b1110;

  typedef struct {
    string         name;
    logic [VW-1:0] exp;
  } exp_t;

  typedef struct packed {
    logic [3:0]             op;
    logic [WIDTH-1:0]       a;
    logic [WIDTH-1:0]       b;
    logic [SHAMT_WIDTH-1:0] sh;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [WIDTH-1:0] hi_m = '0;
  logic [WIDTH-1:0] lo_m = '0;

  multicycle_alu_if #(.WIDTH(WIDTH), .SHAMT_WIDTH(SHAMT_WIDTH)) bus ();

  multicycle_alu #(.WIDTH(WIDTH), .SHAMT_WIDTH(SHAMT_WIDTH), .MEM_BASE(32'h0040_0000)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Behavioural reference: {ALUResult, Zero, HI, LO}.
  function automatic logic [VW-1:0] model(input logic [3:0] op, input logic [WIDTH-1:0] a,
                                          input logic [WIDTH-1:0] b, input logic [SHAMT_WIDTH-1:0] sh);
    logic [WIDTH-1:0]   r, h, l;
    logic [2*WIDTH-1:0] p;
    h = hi_m; l = lo_m; r = '0;
    case (op)
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_NOR: r = ~(a | b);
      OP_ADD: r = a + b;
      OP_SUB, OP_BEQ: r = a - b;
      OP_SLL: r = b << sh;
      OP_SRL: r = b >> sh;
      OP_SRA: r = $signed(b) >>> sh;
      OP_LUI: r = {b[15:0], 16'h0000};
      OP_MEM: r = (a + b - 32'h0040_0000) >> 2;
      OP_JR:  r = a;
      OP_MULTU: begin p = {32'h0, a} * {32'h0, b}; h = p[63:32]; l = p[31:0]; r = l; end
      OP_DIVU: begin
        if (b == 0) begin l = '1; h = a; end
        else begin l = a / b; h = a % b; end
        r = l;
      end
      default: r = '0;
    endcase
    return {r, (r == 0), h, l};
  endfunction

  task automatic issue(input string name, input logic [3:0] op, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b, input logic [SHAMT_WIDTH-1:0] sh);
    exp_t e;
    e.name = name;
    e.exp  = model(op, a, b, sh);
    hi_m   = e.exp[2*WIDTH-1:WIDTH];
    lo_m   = e.exp[WIDTH-1:0];
    sb.push_back(e);
    bus.ALUOperation = op; bus.A = a; bus.B = b; bus.Shamt = sh; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  // Waits for done; edge_idx is the edge (relative to E0) whose update done reports.
  task automatic wait_done(input int limit, output int edge_idx, output int busy_n, output bit clash);
    edge_idx = -1; busy_n = 0; clash = 1'b0;
    for (int k = 1; k <= limit; k++) begin
      @(negedge clk);
      if (bus.busy) busy_n++;
      if (bus.busy && bus.done) clash = 1'b1;
      if (bus.done) begin
        edge_idx = k - 1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    logic [VW+1:0] got;
    int ed, bn; bit cl;
    reset = 1'b1; bus.start = 1'b0; bus.ALUOperation = '0; bus.A = '0; bus.B = '0; bus.Shamt = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    got = {bus.busy, bus.done, bus.Zero, bus.ALUResult, bus.HI, bus.LO};
    n_checks++;
    if (got !== '0) begin n_fail++; $display("FAIL reset_state: got %h expected 0", got); end
    // reset and start together: request must be dropped
    bus.ALUOperation = OP_ADD; bus.A = 32'd5; bus.B = 32'd7; bus.start = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; bus.start = 1'b0;
    wait_done(5, ed, bn, cl);
    n_checks++;
    if (ed !== -1) begin n_fail++; $display("FAIL reset_start_done: got edge %0d expected none", ed); end
    n_checks++;
    if (bus.ALUResult !== '0) begin n_fail++; $display("FAIL reset_start_result: got %h expected 0", bus.ALUResult); end
  endtask

  task automatic test_single_cycle;
    vec_t tab [15];
    exp_t e;
    int ed, bn; bit cl;
    tab = '{
      '{OP_ADD, 32'd5,          32'd7,          5'd0},
      '{OP_BEQ, 32'd9,          32'd9,          5'd0},
      '{OP_SRA, 32'd0,          32'h8000_0000,  5'd4},
      '{OP_MEM, 32'h0040_0000,  32'd8,          5'd0},
      '{OP_LUI, 32'd0,          32'h0000_1234,  5'd0},
      '{4'b1111, 32'hDEAD_BEEF, 32'h1234_5678,  5'd3},
      '{OP_AND, 32'hF0F0_FF00,  32'h0FF0_F0F0,  5'd0},
      '{OP_OR,  32'hF000_000F,  32'h0F00_00F0,  5'd0},
      '{OP_NOR, 32'hF000_000F,  32'h0F00_00F0,  5'd0},
      '{OP_SUB, 32'd3,          32'd10,         5'd0},
      '{OP_SLL, 32'd0,          32'h8000_0001,  5'd31},
      '{OP_SRL, 32'd0,          32'h8000_0000,  5'd31},
      '{OP_SRA, 32'd0,          32'h7000_0000,  5'd4},
      '{OP_JR,  32'h0040_1234,  32'd0,          5'd0},
      '{OP_MEM, 32'h0000_0000,  32'd0,          5'd0}
    };
    foreach (tab[i]) begin
      issue($sformatf("single_%0d_op%b", i, tab[i].op), tab[i].op, tab[i].a, tab[i].b, tab[i].sh);
      wait_done(4, ed, bn, cl);
      n_checks++;
      if (ed !== 0 || bn !== 0) begin
        n_fail++; $display("FAIL single_%0d_timing: got edge %0d busy %0d expected edge 0 busy 0", i, ed, bn);
      end
      e = sb.pop_front();
      n_checks++;
      if ({bus.ALUResult, bus.Zero, bus.HI, bus.LO} !== e.exp) begin
        n_fail++; $display("FAIL %s: got %h expected %h", e.name, {bus.ALUResult, bus.Zero, bus.HI, bus.LO}, e.exp);
      end
    end
  endtask

  task automatic test_iterative;
    vec_t tab [6];
    exp_t e;
    int ed, bn; bit cl;
    tab = '{
      '{OP_MULTU, 32'hFFFF_FFFF, 32'd2,          5'd0},
      '{OP_DIVU,  32'd100,       32'd7,          5'd0},
      '{OP_DIVU,  32'd5,         32'd0,          5'd0},
      '{OP_MULTU, $urandom(),    $urandom(),     5'd0},
      '{OP_DIVU,  $urandom(),    32'(($urandom() >> 12) | 1), 5'd0},
      '{OP_MULTU, 32'd0,         32'h1234_5678,  5'd0}
    };
    foreach (tab[i]) begin
      issue($sformatf("iter_%0d_op%b", i, tab[i].op), tab[i].op, tab[i].a, tab[i].b, tab[i].sh);
      wait_done(WIDTH + 8, ed, bn, cl);
      n_checks++;
      if (ed !== WIDTH || bn !== WIDTH || cl) begin
        n_fail++; $display("FAIL iter_%0d_timing: got edge %0d busy %0d clash %0d expected edge %0d busy %0d clash 0",
                           i, ed, bn, cl, WIDTH, WIDTH);
      end
      e = sb.pop_front();
      n_checks++;
      if ({bus.ALUResult, bus.Zero, bus.HI, bus.LO} !== e.exp) begin
        n_fail++; $display("FAIL %s: got %h expected %h", e.name, {bus.ALUResult, bus.Zero, bus.HI, bus.LO}, e.exp);
      end
    end
  endtask

  task automatic test_back_to_back;
    exp_t e;
    int ed, bn; bit cl;
    issue("multu_busy_start", OP_MULTU, 32'h1234_5678, 32'h0000_9ABC, 5'd0);
    repeat (9) @(negedge clk);
    bus.ALUOperation = OP_ADD; bus.A = 32'd1; bus.B = 32'd2; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(WIDTH + 8, ed, bn, cl);
    n_checks++;
    if (ed !== WIDTH - 10 || cl) begin
      n_fail++; $display("FAIL busy_start_timing: got edge %0d clash %0d expected edge %0d clash 0", ed, cl, WIDTH - 10);
    end
    e = sb.pop_front();
    n_checks++;
    if ({bus.ALUResult, bus.Zero, bus.HI, bus.LO} !== e.exp) begin
      n_fail++; $display("FAIL %s: got %h expected %h", e.name, {bus.ALUResult, bus.Zero, bus.HI, bus.LO}, e.exp);
    end
    // start raised in the done cycle must be accepted at that edge
    issue("divu_back_to_back", OP_DIVU, 32'hFFFF_FFF0, 32'd3, 5'd0);
    wait_done(WIDTH + 8, ed, bn, cl);
    n_checks++;
    if (ed !== WIDTH || bn !== WIDTH) begin
      n_fail++; $display("FAIL back_to_back_timing: got edge %0d busy %0d expected edge %0d busy %0d", ed, bn, WIDTH, WIDTH);
    end
    e = sb.pop_front();
    n_checks++;
    if ({bus.ALUResult, bus.Zero, bus.HI, bus.LO} !== e.exp) begin
      n_fail++; $display("FAIL %s: got %h expected %h", e.name, {bus.ALUResult, bus.Zero, bus.HI, bus.LO}, e.exp);
    end
  endtask

  task automatic test_reset_abort;
    logic [VW+1:0] got;
    exp_t e;
    int ed, bn; bit cl;
    bus.ALUOperation = OP_DIVU; bus.A = 32'd1000; bus.B = 32'd3; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (14) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    hi_m = '0; lo_m = '0;
    got = {bus.busy, bus.done, bus.Zero, bus.ALUResult, bus.HI, bus.LO};
    n_checks++;
    if (got !== '0) begin n_fail++; $display("FAIL abort_outputs: got %h expected 0", got); end
    wait_done(WIDTH + 8, ed, bn, cl);
    n_checks++;
    if (ed !== -1 || bn !== 0) begin
      n_fail++; $display("FAIL abort_no_done: got edge %0d busy %0d expected none and 0", ed, bn);
    end
    issue("add_after_abort", OP_ADD, 32'd40, 32'd2, 5'd0);
    wait_done(4, ed, bn, cl);
    n_checks++;
    if (ed !== 0) begin n_fail++; $display("FAIL add_after_abort_timing: got edge %0d expected 0", ed); end
    e = sb.pop_front();
    n_checks++;
    if ({bus.ALUResult, bus.Zero, bus.HI, bus.LO} !== e.exp) begin
      n_fail++; $display("FAIL %s: got %h expected %h", e.name, {bus.ALUResult, bus.Zero, bus.HI, bus.LO}, e.exp);
    end
  endtask

  initial begin
    test_reset();
    test_single_cycle();
    test_iterative();
    test_back_to_back();
    test_reset_abort();
    n_checks++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL scoreboard_drained: got %0d left expected 0", sb.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
